mimc_mod_reduce: RTL and testbench

MIMC_MOD_REDUCE -- requirements
Module: mimc_mod_reduce

---
 rtl/mimc_mod_reduce.sv | 119 +++++++++++
 tb/tb_mimc_mod_reduce.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mimc_mod_reduce.sv
// mimc_mod_reduce
//   Sequential restoring-division reducer: computes x mod PRIME (and,
//   optionally, floor(x / PRIME)) one operand bit per clock, MSB first.
//   Parameters:
//     WIDTH    - modulus / remainder width
//     IN_WIDTH - operand width (IN_WIDTH >= WIDTH)
//     PRIME    - modulus, 1 < PRIME < 2^WIDTH
//   Ports:
//     clk, rst_n           - clock, asynchronous active-low reset
//     in_valid / in_ready  - operand handshake (accepted only in IDLE)
//     in_data              - operand x
//     out_valid / out_ready- result handshake (held until out_ready)
//     out_rem              - x mod PRIME, zero while out_valid=0
//     out_quot             - floor(x / PRIME), zero while out_valid=0
//   Build option:
//     MIMC_MOD_QUOTIENT_EN - when defined, adds out_quot and the quotient
//                            shift register; remainder and timing unchanged.
module mimc_mod_reduce #(
   parameter int unsigned      WIDTH    = 256,
   parameter int unsigned      IN_WIDTH = 512,
   parameter logic [WIDTH-1:0] PRIME    = 256'd21888242871839275222246405745257275088548364400416034343698204186575808495617
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_rem
`ifdef MIMC_MOD_QUOTIENT_EN
   ,
   output logic [IN_WIDTH-1:0] out_quot
`endif
);

   localparam int unsigned CW = $clog2(IN_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic [IN_WIDTH-1:0] x_q;
   logic [WIDTH-1:0]    r_q;
   logic [CW-1:0]       cnt_q;
   logic                last_step;

   logic [WIDTH:0]      r_ext;
   logic [WIDTH:0]      r_sub;
   logic                ge;
   logic [WIDTH-1:0]    r_step;

   // One restoring step: bring in the next operand bit, subtract PRIME if it fits.
   // Remainder stays below PRIME, so WIDTH+1 bits always suffice.
   always_comb begin
      r_ext  = {r_q, x_q[IN_WIDTH-1]};
      ge     = (r_ext >= {1'b0, PRIME});
      r_sub  = r_ext - {1'b0, PRIME};
      r_step = ge ? r_sub[WIDTH-1:0] : r_ext[WIDTH-1:0];
   end

   assign last_step = (cnt_q == CW'(IN_WIDTH - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = BUSY;
         BUSY:    if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_rem   = out_valid ? r_q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q   <= in_data;
                  r_q   <= '0;
                  cnt_q <= '0;
               end
            end
            BUSY: begin
               x_q   <= x_q << 1;
               r_q   <= r_step;
               cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MIMC_MOD_QUOTIENT_EN
   logic [IN_WIDTH-1:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (state_q == IDLE && in_valid) begin
         q_q <= '0;
      end else if (state_q == BUSY) begin
         q_q <= (q_q << 1) | IN_WIDTH'(ge);
      end
   end

   assign out_quot = out_valid ? q_q : '0;
`endif

endmodule

// File: tb/tb_mimc_mod_reduce.sv
module tb_mimc_mod_reduce;

   localparam logic [255:0] P = 256'd21888242871839275222246405745257275088548364400416034343698204186575808495617;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // small instance: PRIME=13, WIDTH=4, IN_WIDTH=8
   logic       s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
   logic [7:0] s_in_data = '0;
   logic [3:0] s_out_rem;
   logic [7:0] s_out_quot;

   // default instance
   logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
   logic [511:0] b_in_data = '0;
   logic [255:0] b_out_rem;
   logic [511:0] b_out_quot;

   mimc_mod_reduce #(.WIDTH(4), .IN_WIDTH(8), .PRIME(4'd13)) u_small (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_rem(s_out_rem)
`ifdef MIMC_MOD_QUOTIENT_EN
      , .out_quot(s_out_quot)
`endif
   );

   mimc_mod_reduce u_big (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rem(b_out_rem)
`ifdef MIMC_MOD_QUOTIENT_EN
      , .out_quot(b_out_quot)
`endif
   );

`ifndef MIMC_MOD_QUOTIENT_EN
   assign s_out_quot = '0;
   assign b_out_quot = '0;
`endif

   typedef struct {
      logic [7:0] din;
      logic [3:0] rem;
      logic [7:0] quot;
   } vec_t;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accept edge counts as edge 1; returns the edge on which out_valid is seen.
   task automatic run_small(input logic [7:0] din, output int lat);
      @(negedge clk);
      check("s_in_ready_idle", s_in_ready, 1);
      s_in_valid = 1'b1;
      s_in_data  = din;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      s_in_data  = '0;
      lat = 1;
      check("s_busy_rem_zero", s_out_rem, 0);
      while (!s_out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_small();
      @(negedge clk);
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
      check("s_leave_valid", s_out_valid, 0);
      check("s_leave_ready", s_in_ready, 1);
      check("s_leave_rem", s_out_rem, 0);
   endtask

   task automatic run_big(input logic [511:0] din, output int lat);
      @(negedge clk);
      check("b_in_ready_idle", b_in_ready, 1);
      b_in_valid = 1'b1;
      b_in_data  = din;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_in_data  = '0;
      lat = 1;
      while (!b_out_valid && lat < 600) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b_latency", lat, 513);
      @(negedge clk);
   endtask

   initial begin
      vec_t         vecs[7];
      int           lat;
      logic [511:0] d;

      vecs[0] = '{8'd200, 4'd5,  8'd15};
      vecs[1] = '{8'd255, 4'd8,  8'd19};
      vecs[2] = '{8'd13,  4'd0,  8'd1};
      vecs[3] = '{8'd0,   4'd0,  8'd0};
      vecs[4] = '{8'd12,  4'd12, 8'd0};
      vecs[5] = '{8'd14,  4'd1,  8'd1};
      vecs[6] = '{8'd169, 4'd0,  8'd13};

      #12;
      check("rst_in_ready", s_in_ready, 1);
      check("rst_out_valid", s_out_valid, 0);
      check("rst_out_rem", s_out_rem, 0);
      check("rst_b_in_ready", b_in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_small(vecs[i].din, lat);
         check("s_latency", lat, 9);
         check("s_rem", s_out_rem, vecs[i].rem);
`ifdef MIMC_MOD_QUOTIENT_EN
         check("s_quot", s_out_quot, vecs[i].quot);
`endif
         release_small();
      end

      // backpressure in DONE with in_valid toggling
      run_small(8'd200, lat);
      check("bp_latency", lat, 9);
      for (int unsigned c = 0; c < 20; c++) begin
         @(negedge clk);
         s_in_valid = c[0];
         s_in_data  = 8'd7;
         @(posedge clk); #1;
         check("bp_valid", s_out_valid, 1);
         check("bp_rem", s_out_rem, 5);
         check("bp_in_ready", s_in_ready, 0);
`ifdef MIMC_MOD_QUOTIENT_EN
         check("bp_quot", s_out_quot, 15);
`endif
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      release_small();
      // the operand offered during DONE must not have been taken
      repeat (12) @(posedge clk);
      #1;
      check("bp_no_operand", s_out_valid, 0);
      check("bp_idle_ready", s_in_ready, 1);

      // reset during BUSY after three steps
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data  = 8'd200;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rb_in_ready", s_in_ready, 1);
      check("rb_out_valid", s_out_valid, 0);
      check("rb_out_rem", s_out_rem, 0);
      repeat (10) @(posedge clk);
      #1;
      check("rb_no_result", s_out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_small(8'd200, lat);
      check("rb_latency", lat, 9);
      check("rb_rem", s_out_rem, 5);
`ifdef MIMC_MOD_QUOTIENT_EN
      check("rb_quot", s_out_quot, 15);
`endif

      // reset while holding a result: drops without a clock edge
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rd_out_valid", s_out_valid, 0);
      check("rd_out_rem", s_out_rem, 0);
      check("rd_in_ready", s_in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // default-parameter instance
      d = {256'd0, P} - 512'd1;
      run_big(d, lat);
      check("b_rem_pm1", b_out_rem, {256'd0, P} - 512'd1);
`ifdef MIMC_MOD_QUOTIENT_EN
      check("b_quot_pm1", b_out_quot, 0);
`endif
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      check("b_leave_valid", b_out_valid, 0);

      d = {256'd0, P} + {256'd0, P} + 512'd7;
      run_big(d, lat);
      check("b_rem_2p7", b_out_rem, 7);
`ifdef MIMC_MOD_QUOTIENT_EN
      check("b_quot_2p7", b_out_quot, 2);
`endif
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      check("b_leave_valid2", b_out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
